// File: rtl/bypass_hazard_ctrl_pkg.sv
// Shared types and constants for the register-read bypass scheduler.
package bypass_hazard_ctrl_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned SEL_W = 2;

  localparam logic [SEL_W-1:0] SEL_RF  = 2'd0;
  localparam logic [SEL_W-1:0] SEL_EX  = 2'd1;
  localparam logic [SEL_W-1:0] SEL_MEM = 2'd2;
  localparam logic [SEL_W-1:0] SEL_WB  = 2'd3;

  // One tracked pipeline stage: destination of an in-flight writer.
  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] dest;
    logic             load;
  } stage_entry_t;

  function automatic logic entry_hit(input stage_entry_t e, input logic [REG_W-1:0] src);
    return e.v && (e.dest == src) && (src != '0);
  endfunction

endpackage

// File: rtl/bhc_src_match.sv
// Priority match of one source register against EX/MEM/WB, youngest first.
module bhc_src_match
  import bypass_hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] src_i,
  input  stage_entry_t     ex_i,
  input  stage_entry_t     mem_i,
  input  stage_entry_t     wb_i,
  output logic [SEL_W-1:0] sel_o,
  output logic             load_hit_o
);

  logic ex_hit, mem_hit, wb_hit;

  assign ex_hit  = entry_hit(ex_i, src_i);
  assign mem_hit = entry_hit(mem_i, src_i);
  assign wb_hit  = entry_hit(wb_i, src_i);

  always_comb begin
    sel_o      = SEL_RF;
    load_hit_o = 1'b0;
    if (ex_hit) begin
      // A load in EX has no result yet; older stages hold stale data.
      if (ex_i.load) begin
        load_hit_o = 1'b1;
      end else begin
        sel_o = SEL_EX;
      end
    end else if (mem_hit) begin
      sel_o = SEL_MEM;
    end else if (wb_hit) begin
      sel_o = SEL_WB;
    end
  end

endmodule

// File: rtl/bypass_hazard_ctrl.sv
// Bypass-select and load-use stall scheduler tracking EX/MEM/WB destinations.
module bypass_hazard_ctrl
  import bypass_hazard_ctrl_pkg::*;
#(
  parameter string       NAME  = "BHC",
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             IdValid,
  input  logic [REG_W-1:0] IdRs,
  input  logic [REG_W-1:0] IdRt,
  input  logic [REG_W-1:0] IdDest,
  input  logic             IdWrites,
  input  logic             IdIsLoad,
  input  logic             MemStall,
  input  logic             Flush,
  output logic [SEL_W-1:0] SelRs,
  output logic [SEL_W-1:0] SelRt,
  output logic             Stall,
  output logic [CNT_W-1:0] StallCount,
  input  logic             Comment
);

  stage_entry_t     ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_hit_rs, load_hit_rt;

  bhc_src_match u_match_rs (
    .src_i      (IdRs),
    .ex_i       (ex_q),
    .mem_i      (mem_q),
    .wb_i       (wb_q),
    .sel_o      (SelRs),
    .load_hit_o (load_hit_rs)
  );

  bhc_src_match u_match_rt (
    .src_i      (IdRt),
    .ex_i       (ex_q),
    .mem_i      (mem_q),
    .wb_i       (wb_q),
    .sel_o      (SelRt),
    .load_hit_o (load_hit_rt)
  );

  assign Stall      = IdValid & (load_hit_rs | load_hit_rt);
  assign StallCount = cnt_q;

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    cnt_d = cnt_q;
    if (!MemStall) begin
      wb_d      = mem_q;
      mem_d     = ex_q;
      // Stalled or squashed decode instructions enter EX as a bubble.
      ex_d.v    = IdValid & IdWrites & (IdDest != '0) & ~Stall & ~Flush;
      ex_d.dest = IdDest;
      ex_d.load = IdIsLoad;
      if (Stall) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end

`ifndef SYNTHESIS
  always @(SelRs or SelRt or Stall) begin
    if (Comment) begin
      $display("%s: rs=%0d rt=%0d sel_rs=%0d sel_rt=%0d stall=%0b",
               NAME, IdRs, IdRt, SelRs, SelRt, Stall);
    end
  end
`endif

endmodule

// File: tb/tb_bypass_hazard_ctrl.sv
// Directed, table-driven bench for bypass_hazard_ctrl.
module tb_bypass_hazard_ctrl;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        IdValid, IdWrites, IdIsLoad, MemStall, Flush, Comment;
  logic [4:0]  IdRs, IdRt, IdDest;
  logic [1:0]  SelRs, SelRt;
  logic        Stall;
  logic [31:0] StallCount;

  int checks   = 0;
  int failures = 0;
  int exp_cnt;

  bypass_hazard_ctrl #(.NAME("BHC"), .CNT_W(32)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .IdValid    (IdValid),
    .IdRs       (IdRs),
    .IdRt       (IdRt),
    .IdDest     (IdDest),
    .IdWrites   (IdWrites),
    .IdIsLoad   (IdIsLoad),
    .MemStall   (MemStall),
    .Flush      (Flush),
    .SelRs      (SelRs),
    .SelRt      (SelRt),
    .Stall      (Stall),
    .StallCount (StallCount),
    .Comment    (Comment)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       v;
    logic [4:0] rs, rt, dest;
    logic       wr, ld, ms, fl;
    logic [1:0] e_rs, e_rt;
    logic       e_stall;
    int         e_cnt;
  } vec_t;

  localparam int NV = 27;
  vec_t tbl[NV];

  function automatic vec_t mk(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] dest, input logic wr, input logic ld,
                              input logic ms, input logic fl, input logic [1:0] e_rs,
                              input logic [1:0] e_rt, input logic e_stall, input int e_cnt);
    vec_t t;
    t.v = v; t.rs = rs; t.rt = rt; t.dest = dest; t.wr = wr; t.ld = ld; t.ms = ms; t.fl = fl;
    t.e_rs = e_rs; t.e_rt = e_rt; t.e_stall = e_stall; t.e_cnt = e_cnt;
    return t;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] dest, input logic wr, input logic ld,
                       input logic ms, input logic fl);
    IdValid = v; IdRs = rs; IdRt = rt; IdDest = dest;
    IdWrites = wr; IdIsLoad = ld; MemStall = ms; Flush = fl;
    #1;
  endtask

  task automatic check_out(input string tag, input int e_rs, input int e_rt,
                           input int e_stall, input int e_cnt);
    check({tag, ".sel_rs"}, int'(SelRs), e_rs);
    check({tag, ".sel_rt"}, int'(SelRt), e_rt);
    check({tag, ".stall"}, int'(Stall), e_stall);
    check({tag, ".count"}, int'(StallCount), e_cnt);
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // v  rs  rt  dst wr ld ms fl | rs rt st cnt
    tbl[0]  = mk(0,  0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1,  0,  0,  5, 1, 0, 0, 0, 0, 0, 0, 0); // ADD r5
    tbl[2]  = mk(1,  5,  0,  0, 0, 0, 0, 0, 1, 0, 0, 0);
    tbl[3]  = mk(1,  5,  0,  0, 0, 0, 0, 0, 2, 0, 0, 0);
    tbl[4]  = mk(1,  5,  0,  0, 0, 0, 0, 0, 3, 0, 0, 0);
    tbl[5]  = mk(1,  5,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[6]  = mk(1,  0,  0,  8, 1, 1, 0, 0, 0, 0, 0, 0); // LW r8
    tbl[7]  = mk(1,  0,  8,  0, 0, 0, 0, 0, 0, 0, 1, 0);
    tbl[8]  = mk(1,  0,  8,  0, 0, 0, 0, 0, 0, 2, 0, 1);
    tbl[9]  = mk(1,  0,  0,  3, 1, 0, 0, 0, 0, 0, 0, 1); // ADD r3
    tbl[10] = mk(1,  3,  0,  3, 1, 0, 0, 0, 1, 0, 0, 1); // ADD r3 again
    tbl[11] = mk(1,  3,  3,  0, 0, 0, 0, 0, 1, 1, 0, 1); // EX beats MEM
    tbl[12] = mk(1,  3,  3,  0, 0, 0, 0, 0, 2, 2, 0, 1); // MEM beats WB
    tbl[13] = mk(1,  0,  3,  0, 1, 0, 0, 0, 0, 3, 0, 1); // write r0
    tbl[14] = mk(1,  0,  0,  0, 1, 0, 0, 0, 0, 0, 0, 1);
    tbl[15] = mk(1,  0,  0,  9, 1, 0, 0, 1, 0, 0, 0, 1); // flushed r9
    tbl[16] = mk(1,  9,  0,  0, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[17] = mk(1,  0,  0,  6, 1, 1, 0, 0, 0, 0, 0, 1); // LW r6
    tbl[18] = mk(1,  6,  6,  7, 1, 0, 0, 1, 0, 0, 1, 1); // stall + flush
    tbl[19] = mk(1,  6,  7,  0, 0, 0, 0, 0, 2, 0, 0, 2);
    tbl[20] = mk(1,  6,  0, 10, 1, 1, 0, 0, 3, 0, 0, 2); // LW r10
    tbl[21] = mk(0, 10,  0, 11, 1, 0, 0, 0, 0, 0, 0, 2); // invalid decode: no stall
    tbl[22] = mk(1, 10, 11,  0, 0, 0, 0, 0, 2, 0, 0, 2);
    tbl[23] = mk(1, 10,  0, 12, 1, 0, 0, 0, 3, 0, 0, 2); // ADD r12
    tbl[24] = mk(1, 12,  0, 13, 1, 1, 0, 0, 1, 0, 0, 2); // LW r13
    tbl[25] = mk(1, 13, 12,  0, 0, 0, 0, 0, 0, 2, 1, 2); // other source still bypassed
    tbl[26] = mk(1, 13, 12,  0, 0, 0, 0, 0, 2, 3, 0, 3);

    Comment = 1'b0;
    RESET   = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check_out("reset", 0, 0, 0, 0);
    #10;
    RESET = 1'b1;
    step();

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].v, tbl[i].rs, tbl[i].rt, tbl[i].dest, tbl[i].wr, tbl[i].ld,
            tbl[i].ms, tbl[i].fl);
      check_out($sformatf("vec%0d", i), int'(tbl[i].e_rs), int'(tbl[i].e_rt),
                int'(tbl[i].e_stall), tbl[i].e_cnt);
      step();
    end
    exp_cnt = 3;

    // Drain, then freeze the pipe under a load-use hazard.
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      step();
    end
    drive(1, 0, 0, 4, 1, 1, 0, 0);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1, 4, 0, 0, 0, 0, 1, 0);
      check_out($sformatf("memstall%0d", i), 0, 0, 1, exp_cnt);
      step();
    end
    drive(1, 4, 0, 0, 0, 0, 0, 0);
    check_out("memstall_release", 0, 0, 1, exp_cnt);
    step();
    exp_cnt++;
    drive(1, 4, 0, 0, 0, 0, 0, 0);
    check_out("memstall_after", 2, 0, 0, exp_cnt);
    step();

    // Asynchronous reset in the middle of a hazard.
    drive(1, 0, 0, 20, 1, 1, 0, 0);
    step();
    drive(1, 20, 20, 0, 0, 0, 0, 0);
    check_out("pre_reset", 0, 0, 1, exp_cnt);
    RESET = 1'b0;
    #1;
    check_out("async_reset", 0, 0, 0, 0);
    step();
    #2;
    RESET = 1'b1;
    step();
    check_out("post_reset", 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bypass_hazard_ctrl.md
Name: bypass_hazard_ctrl

Overview:
- Scheduler for the register-read bypass path.
- Tracks destination registers of in-flight instructions in the EX, MEM and WB stages.
- For each decode-stage source operand, selects which stage's result feeds the bypass mux.
- Raises a load-use stall when a needed value is not yet produced, and drops squashed instructions on branch-mispredict flush.

Parameters:
NAME, "BHC", tag printed in debug $display lines when Comment is high
CNT_W, 32, width of the hazard-stall performance counter

Ports:
CLK  in  1  clock; all state updates on rising edge
RESET  in  1  asynchronous active-low reset
IdValid  in  1  decode stage holds a valid instruction
IdRs  in  5  source register A of decode instruction
IdRt  in  5  source register B of decode instruction
IdDest  in  5  destination register of decode instruction
IdWrites  in  1  decode instruction writes IdDest
IdIsLoad  in  1  decode instruction is a load (result available only after MEM)
MemStall  in  1  memory not ready; whole tracked pipeline freezes
Flush  in  1  mispredict; decode instruction is squashed
SelRs  out  2  bypass select for A: 0=regfile, 1=EX result, 2=MEM result, 3=WB data
SelRt  out  2  bypass select for B, same encoding
Stall  out  1  load-use hazard; decode must hold
StallCount  out  CNT_W  number of cycles Stall was asserted while not frozen
Comment  in  1  enables debug $display

Behaviour:
- Reset: asynchronous on RESET low.
  - EX, MEM and WB entries all invalid; StallCount=0.
  - Hence SelRs=SelRt=0 and Stall=0.
- State: three entries EX, MEM, WB, each holding {V, Dest[4:0], Load}.
  - An entry is only made valid when IdWrites=1 and IdDest!=0.
- Outputs are combinational from current state plus Id* inputs (zero latency).
- Match rule for a source s: entry valid AND entry.Dest==s AND s!=0.
  - Register 0 always selects 0.
- Priority is youngest first: EX > MEM > WB > regfile.
  - EX match with EX.Load=0 gives Sel=1.
  - MEM match gives Sel=2.
  - WB match gives Sel=3.
  - No match gives Sel=0.
- Load-use hazard: EX match with EX.Load=1 for either source, while IdValid=1.
  - Stall=1.
  - The Sel for that source is 0. The other source's Sel is still computed normally.
- Hazard is qualified only by IdValid, not by Flush. The decode stage is responsible for ignoring Stall during Flush.
- Sequential update at the clock edge:
  - MemStall=1: hold all entries. StallCount holds. Outputs keep their combinational values.
  - MemStall=0, advancing: WB<=MEM; MEM<=EX.
  - EX <= {IdValid & IdWrites & (IdDest!=0) & ~Stall & ~Flush, IdDest, IdIsLoad}.
- Stall inserts a bubble in EX for exactly one cycle. On the next cycle the load is in MEM, giving Sel=2.
- Flush and Stall in the same cycle: Flush wins; EX gets a bubble. The stall count still increments if Stall=1.
- StallCount increments when Stall=1 and MemStall=0. It wraps at 2^CNT_W.
- Reset mid-operation clears all entries immediately; the pending hazard disappears in the same cycle.
- Debug: on each output change with Comment=1, print NAME, IdRs/IdRt, SelRs/SelRt and Stall.

Decomposition:
- Shared package holds:
  - localparams SEL_RF=0, SEL_EX=1, SEL_MEM=2, SEL_WB=3;
  - the stage-entry field widths (REG_W=5).
- One sub-module, bhc_src_match: per-source priority match over EX/MEM/WB producing {Sel, LoadHit}. It is instantiated twice, for Rs and Rt.

Test Plan:
- Reset low, then high with no issue -> SelRs=SelRt=0, Stall=0, StallCount=0.
- Issue ADD dest=5; next cycle IdRs=5 -> SelRs=1. One cycle later SelRs=2; one cycle after that SelRs=3; one cycle after that SelRs=0.
- Issue LW dest=8; next cycle IdRt=8 -> Stall=1, SelRt=0, StallCount=1. Following cycle Stall=0, SelRt=2.
- Dest=3 in MEM (ADD) and dest=3 in EX (ADD), IdRs=3 -> SelRs=1, confirming the youngest wins.
- IdDest=0 with IdWrites=1, then IdRs=0 -> SelRs=0 in every following cycle.
- LW dest=4 in EX, IdRs=4, MemStall=1 for 3 cycles -> Stall=1 throughout, StallCount unchanged, entries held. After MemStall drops, StallCount=1 and the next cycle SelRs=2.
- Flush=1 with IdWrites=1, IdDest=9 -> next cycle IdRs=9 gives SelRs=0.
